// File: rtl/rip_common_pkg.sv
// Shared RV32I/Zicsr decode types: one-hot opcode vector, immediate formats,
// encoding constants and the decoded-entry record carried through the stage.
package rip_common;

  typedef struct packed {
    logic LUI, AUIPC, JAL, JALR;
    logic BEQ, BNE, BLT, BGE, BLTU, BGEU;
    logic LB, LH, LW, LBU, LHU;
    logic SB, SH, SW;
    logic ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI;
    logic ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND;
    logic CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI;
  } inst_t;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_NONE
  } imm_fmt_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_LB   = 3'd0, F3_LH = 3'd1, F3_LW = 3'd2;
  localparam logic [2:0] F3_LBU  = 3'd4, F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB   = 3'd0, F3_SH = 3'd1, F3_SW = 3'd2;
  localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3, F3_XOR = 3'd4, F3_SR = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6, F3_AND = 3'd7;
  localparam logic [2:0] F3_CSRRW  = 3'd1, F3_CSRRS  = 3'd2, F3_CSRRC  = 3'd3;
  localparam logic [2:0] F3_CSRRWI = 3'd5, F3_CSRRSI = 3'd6, F3_CSRRCI = 3'd7;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    inst_t       inst;
    logic [31:0] imm;
    logic [4:0]  zimm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] csr;
    logic        illegal;
  } dec_t;

  function automatic logic [31:0] expand_imm(imm_fmt_t f, logic [31:0] w);
    logic [31:0] r;
    case (f)
      IMM_I:     r = {{20{w[31]}}, w[31:20]};
      IMM_S:     r = {{20{w[31]}}, w[31:25], w[11:7]};
      IMM_B:     r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      IMM_U:     r = {w[31:12], 12'b0};
      IMM_J:     r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      IMM_SHAMT: r = {27'b0, w[24:20]};
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rip_decode_stage_decoder.sv
// Combinational RV32I/Zicsr decoder: raw word -> one-hot opcode, immediate,
// register/CSR addresses. Anything without a one-hot match is illegal and zeroed.
module rip_decoder
  import rip_common::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);

  logic [6:0] op, f7;
  logic [2:0] f3;
  inst_t      oh;
  imm_fmt_t   fmt;
  logic       rs1_en, rs2_en, rd_en, csr_en, zimm_en, legal;

  assign op = inst_i[6:0];
  assign f3 = inst_i[14:12];
  assign f7 = inst_i[31:25];

  always_comb begin
    oh      = '0;
    fmt     = IMM_NONE;
    rs1_en  = 1'b0;
    rs2_en  = 1'b0;
    rd_en   = 1'b0;
    csr_en  = 1'b0;
    zimm_en = 1'b0;
    case (op)
      OP_LUI:   begin oh.LUI = 1'b1;   fmt = IMM_U; rd_en = 1'b1; end
      OP_AUIPC: begin oh.AUIPC = 1'b1; fmt = IMM_U; rd_en = 1'b1; end
      OP_JAL:   begin oh.JAL = 1'b1;   fmt = IMM_J; rd_en = 1'b1; end
      OP_JALR: begin
        oh.JALR = (f3 == 3'd0);
        fmt = IMM_I; rs1_en = 1'b1; rd_en = 1'b1;
      end
      OP_BRANCH: begin
        fmt = IMM_B; rs1_en = 1'b1; rs2_en = 1'b1;
        case (f3)
          F3_BEQ:  oh.BEQ  = 1'b1;
          F3_BNE:  oh.BNE  = 1'b1;
          F3_BLT:  oh.BLT  = 1'b1;
          F3_BGE:  oh.BGE  = 1'b1;
          F3_BLTU: oh.BLTU = 1'b1;
          F3_BGEU: oh.BGEU = 1'b1;
          default: ;
        endcase
      end
      OP_LOAD: begin
        fmt = IMM_I; rs1_en = 1'b1; rd_en = 1'b1;
        case (f3)
          F3_LB:   oh.LB  = 1'b1;
          F3_LH:   oh.LH  = 1'b1;
          F3_LW:   oh.LW  = 1'b1;
          F3_LBU:  oh.LBU = 1'b1;
          F3_LHU:  oh.LHU = 1'b1;
          default: ;
        endcase
      end
      OP_STORE: begin
        fmt = IMM_S; rs1_en = 1'b1; rs2_en = 1'b1;
        case (f3)
          F3_SB:   oh.SB = 1'b1;
          F3_SH:   oh.SH = 1'b1;
          F3_SW:   oh.SW = 1'b1;
          default: ;
        endcase
      end
      OP_IMM: begin
        fmt = IMM_I; rs1_en = 1'b1; rd_en = 1'b1;
        case (f3)
          F3_ADD:  oh.ADDI  = 1'b1;
          F3_SLT:  oh.SLTI  = 1'b1;
          F3_SLTU: oh.SLTIU = 1'b1;
          F3_XOR:  oh.XORI  = 1'b1;
          F3_OR:   oh.ORI   = 1'b1;
          F3_AND:  oh.ANDI  = 1'b1;
          F3_SLL: begin fmt = IMM_SHAMT; oh.SLLI = (f7 == F7_BASE); end
          F3_SR: begin
            fmt = IMM_SHAMT;
            oh.SRLI = (f7 == F7_BASE);
            oh.SRAI = (f7 == F7_ALT);
          end
          default: ;
        endcase
      end
      OP_REG: begin
        rs1_en = 1'b1; rs2_en = 1'b1; rd_en = 1'b1;
        case (f3)
          F3_ADD: begin oh.ADD = (f7 == F7_BASE); oh.SUB = (f7 == F7_ALT); end
          F3_SR:  begin oh.SRL = (f7 == F7_BASE); oh.SRA = (f7 == F7_ALT); end
          F3_SLL:  oh.SLL  = 1'b1;
          F3_SLT:  oh.SLT  = 1'b1;
          F3_SLTU: oh.SLTU = 1'b1;
          F3_XOR:  oh.XOR  = 1'b1;
          F3_OR:   oh.OR   = 1'b1;
          F3_AND:  oh.AND  = 1'b1;
          default: ;
        endcase
      end
      OP_SYSTEM: begin
        rd_en = 1'b1; csr_en = 1'b1;
        case (f3)
          F3_CSRRW:  begin oh.CSRRW  = 1'b1; rs1_en  = 1'b1; end
          F3_CSRRS:  begin oh.CSRRS  = 1'b1; rs1_en  = 1'b1; end
          F3_CSRRC:  begin oh.CSRRC  = 1'b1; rs1_en  = 1'b1; end
          F3_CSRRWI: begin oh.CSRRWI = 1'b1; zimm_en = 1'b1; end
          F3_CSRRSI: begin oh.CSRRSI = 1'b1; zimm_en = 1'b1; end
          F3_CSRRCI: begin oh.CSRRCI = 1'b1; zimm_en = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Every legal opcode ends in 2'b11, so a set one-hot bit already implies it.
  assign legal = |oh;

  always_comb begin
    dec_o         = '0;
    dec_o.illegal = ~legal;
    if (legal) begin
      dec_o.inst = oh;
      dec_o.imm  = expand_imm(fmt, inst_i);
      dec_o.zimm = zimm_en ? inst_i[19:15] : 5'd0;
      dec_o.rs1  = rs1_en  ? inst_i[19:15] : 5'd0;
      dec_o.rs2  = rs2_en  ? inst_i[24:20] : 5'd0;
      dec_o.rd   = rd_en   ? inst_i[11:7]  : 5'd0;
      dec_o.csr  = csr_en  ? inst_i[31:20] : 12'd0;
    end
  end

endmodule

// File: rtl/rip_decode_stage.sv
// Decode stage: registered output entry plus one skid entry so in_ready is a
// flop. Entries leave strictly in arrival order; flush drops both.
module rip_decode_stage
  import rip_common::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output inst_t       out_inst,
  output logic [31:0] out_imm,
  output logic [4:0]  out_zimm,
  output logic [4:0]  out_rs1_addr,
  output logic [4:0]  out_rs2_addr,
  output logic [4:0]  out_rd_addr,
  output logic [11:0] out_csr_addr,
  output logic [31:0] out_pc,
  output logic        out_illegal
);

  dec_t        dec;
  dec_t        main_q, main_d, skid_q, skid_d;
  logic [31:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic        main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q, rdy_d;
  logic        acc, fire;

  rip_decoder u_dec (
    .inst_i (in_inst),
    .dec_o  (dec)
  );

  assign acc  = in_valid & rdy_q;
  assign fire = main_v_q & out_ready;

  always_comb begin
    main_d    = main_q;
    main_pc_d = main_pc_q;
    main_v_d  = main_v_q;
    skid_d    = skid_q;
    skid_pc_d = skid_pc_q;
    skid_v_d  = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || fire) begin
      // rdy_q == ~skid_v_q, so skid refill and a new accept never coincide
      if (skid_v_q) begin
        main_d    = skid_q;
        main_pc_d = skid_pc_q;
        main_v_d  = 1'b1;
        skid_v_d  = 1'b0;
      end else if (acc) begin
        main_d    = dec;
        main_pc_d = in_pc;
        main_v_d  = 1'b1;
      end else begin
        main_v_d  = 1'b0;
      end
    end else if (acc) begin
      skid_d    = dec;
      skid_pc_d = in_pc;
      skid_v_d  = 1'b1;
    end
    rdy_d = ~skid_v_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q    <= '0;
      main_pc_q <= RESET_PC;
      main_v_q  <= 1'b0;
      skid_q    <= '0;
      skid_pc_q <= '0;
      skid_v_q  <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      main_q    <= main_d;
      main_pc_q <= main_pc_d;
      main_v_q  <= main_v_d;
      skid_q    <= skid_d;
      skid_pc_q <= skid_pc_d;
      skid_v_q  <= skid_v_d;
      rdy_q     <= rdy_d;
    end
  end

  assign in_ready     = rdy_q;
  assign out_valid    = main_v_q;
  assign out_inst     = main_q.inst;
  assign out_imm      = main_q.imm;
  assign out_zimm     = main_q.zimm;
  assign out_rs1_addr = main_q.rs1;
  assign out_rs2_addr = main_q.rs2;
  assign out_rd_addr  = main_q.rd;
  assign out_csr_addr = main_q.csr;
  assign out_pc       = main_pc_q;
  assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_rip_decode_stage.sv
// Directed bench for rip_decode_stage: decode vectors, skid/FIFO order, flush, reset.
module tb_rip_decode_stage;
  import rip_common::*;

  localparam logic [31:0] RPC = 32'h0000_1000;
  localparam logic [31:0] W_ADDI   = 32'hFFF10093;
  localparam logic [31:0] W_LUI    = 32'h123452B7;
  localparam logic [31:0] W_BEQ    = 32'hFE208EE3;
  localparam logic [31:0] W_SLLI   = 32'h01F21193;
  localparam logic [31:0] W_SUB    = 32'h40208033;
  localparam logic [31:0] W_MUL    = 32'h02208033;
  localparam logic [31:0] W_CSRRWI = 32'h3052D0F3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b1;
  logic [31:0] in_inst = '0, in_pc = '0, out_imm, out_pc;
  inst_t       out_inst;
  logic [4:0]  out_zimm, out_rs1_addr, out_rs2_addr, out_rd_addr;
  logic [11:0] out_csr_addr;
  logic        out_illegal;

  int n_run = 0, n_fail = 0;
  inst_t e;

  rip_decode_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_imm(out_imm),
    .out_zimm(out_zimm), .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
    .out_rd_addr(out_rd_addr), .out_csr_addr(out_csr_addr), .out_pc(out_pc),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] pc);
    in_valid = 1'b1; in_inst = w; in_pc = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_dec(input string tag, input inst_t ei, input logic [31:0] imm,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic ill, input logic [31:0] pc);
    check({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
    check({tag, ".inst"}, 64'(out_inst), 64'(ei));
    check({tag, ".imm"}, 64'(out_imm), 64'(imm));
    check({tag, ".rs1"}, 64'(out_rs1_addr), 64'(rs1));
    check({tag, ".rs2"}, 64'(out_rs2_addr), 64'(rs2));
    check({tag, ".rd"}, 64'(out_rd_addr), 64'(rd));
    check({tag, ".ill"}, 64'(out_illegal), 64'(ill));
    check({tag, ".pc"}, 64'(out_pc), 64'(pc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 64'(out_valid), 64'(1'b0));
    check("rst.pc", 64'(out_pc), 64'(RPC));
    check("rst.inst", 64'(out_inst), 64'(0));
    check("rst.imm", 64'(out_imm), 64'(0));
    check("rst.ill", 64'(out_illegal), 64'(1'b0));
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rst.ready", 64'(in_ready), 64'(1'b1));

    // single-word decode vectors, execute always ready
    send(W_ADDI, 32'h100); e = '0; e.ADDI = 1'b1;
    expect_dec("addi", e, 32'hFFFFFFFF, 5'd2, 5'd0, 5'd1, 1'b0, 32'h100);
    send(W_LUI, 32'h104); e = '0; e.LUI = 1'b1;
    expect_dec("lui", e, 32'h12345000, 5'd0, 5'd0, 5'd5, 1'b0, 32'h104);
    send(W_BEQ, 32'h108); e = '0; e.BEQ = 1'b1;
    expect_dec("beq", e, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, 1'b0, 32'h108);
    send(32'h0, 32'h10C); e = '0;
    expect_dec("zero", e, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h10C);
    send(W_SLLI, 32'h110); e = '0; e.SLLI = 1'b1;
    expect_dec("slli", e, 32'd31, 5'd4, 5'd0, 5'd3, 1'b0, 32'h110);
    send(W_SUB, 32'h114); e = '0; e.SUB = 1'b1;
    expect_dec("sub", e, 32'h0, 5'd1, 5'd2, 5'd0, 1'b0, 32'h114);
    send(W_MUL, 32'h118); e = '0;
    expect_dec("badf7", e, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h118);
    send(32'h00000010, 32'h11C); e = '0;
    expect_dec("lowbits", e, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h11C);
    send(W_CSRRWI, 32'h120); e = '0; e.CSRRWI = 1'b1;
    expect_dec("csrrwi", e, 32'h0, 5'd0, 5'd0, 5'd1, 1'b0, 32'h120);
    check("csrrwi.zimm", 64'(out_zimm), 64'(5'd5));
    check("csrrwi.csr", 64'(out_csr_addr), 64'(12'h305));
    tick();
    check("drain.valid", 64'(out_valid), 64'(1'b0));

    // three back-to-back words while execute stalls
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = W_ADDI; in_pc = 32'h200;
    tick();
    check("bp.a_valid", 64'(out_valid), 64'(1'b1));
    check("bp.a_ready", 64'(in_ready), 64'(1'b1));
    in_inst = W_LUI; in_pc = 32'h204;
    tick();
    check("bp.skid_ready", 64'(in_ready), 64'(1'b0));
    check("bp.hold_pc1", 64'(out_pc), 64'(32'h200));
    in_inst = W_BEQ; in_pc = 32'h208;
    tick();
    check("bp.still_blocked", 64'(in_ready), 64'(1'b0));
    check("bp.hold_pc2", 64'(out_pc), 64'(32'h200));
    check("bp.hold_imm", 64'(out_imm), 64'(32'hFFFFFFFF));
    out_ready = 1'b1;
    tick();
    check("bp.b_pc", 64'(out_pc), 64'(32'h204));
    check("bp.b_imm", 64'(out_imm), 64'(32'h12345000));
    check("bp.ready_back", 64'(in_ready), 64'(1'b1));
    tick();
    in_valid = 1'b0;
    check("bp.c_valid", 64'(out_valid), 64'(1'b1));
    check("bp.c_pc", 64'(out_pc), 64'(32'h208));
    check("bp.c_imm", 64'(out_imm), 64'(32'hFFFFFFFC));
    tick();
    check("bp.empty", 64'(out_valid), 64'(1'b0));

    // flush with skid full and a word on the input
    out_ready = 1'b0;
    send(W_ADDI, 32'h300);
    send(W_LUI, 32'h304);
    check("fl.skid_full", 64'(in_ready), 64'(1'b0));
    flush = 1'b1; in_valid = 1'b1; in_inst = W_BEQ; in_pc = 32'h308;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl.valid", 64'(out_valid), 64'(1'b0));
    check("fl.ready", 64'(in_ready), 64'(1'b1));
    out_ready = 1'b1;
    tick();
    check("fl.no_ghost", 64'(out_valid), 64'(1'b0));

    // flush drops a handshake that would otherwise be accepted
    flush = 1'b1; in_valid = 1'b1; in_inst = W_SLLI; in_pc = 32'h400;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl2.valid", 64'(out_valid), 64'(1'b0));
    tick();
    check("fl2.no_ghost", 64'(out_valid), 64'(1'b0));

    // asynchronous reset while an entry is held
    out_ready = 1'b0;
    send(W_ADDI, 32'h500);
    check("ar.held", 64'(out_valid), 64'(1'b1));
    #3 rst_n = 1'b0;
    #1;
    check("ar.valid", 64'(out_valid), 64'(1'b0));
    check("ar.pc", 64'(out_pc), 64'(RPC));
    check("ar.inst", 64'(out_inst), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("ar.ready", 64'(in_ready), 64'(1'b1));
    check("ar.empty", 64'(out_valid), 64'(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
